// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: drives every latch enable/clear
// for load-use stalls, taken-branch flushes and the multicycle mult/div freeze.
module hazard_ctrl #(
    parameter int MD_CYCLES = 32,
    parameter int CW        = $clog2(MD_CYCLES)
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_load,
    input  logic       ex_md_start,
    input  logic       ex_br_taken,
    output logic       pc_en,
    output logic       fd_en,
    output logic       dx_en,
    output logic       xm_en,
    output logic       fd_clr,
    output logic       dx_clr,
    output logic       xm_clr,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_use;

    // Register zero is never a real producer, so it cannot cause a stall.
    assign load_use = ex_load && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_en   = 1'b1;
        fd_en   = 1'b1;
        dx_en   = 1'b1;
        xm_en   = 1'b1;
        fd_clr  = 1'b0;
        dx_clr  = 1'b0;
        xm_clr  = 1'b0;
        md_busy = 1'b0;
        md_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_md_start) begin
                    pc_en   = 1'b0;
                    fd_en   = 1'b0;
                    dx_en   = 1'b0;
                    xm_clr  = 1'b1;
                    cnt_d   = CW'(MD_CYCLES - 2);
                    state_d = MD_RUN;
                end else if (ex_br_taken) begin
                    fd_clr = 1'b1;
                    dx_clr = 1'b1;
                end else if (load_use) begin
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    dx_clr = 1'b1;
                end
            end
            MD_RUN: begin
                pc_en   = 1'b0;
                fd_en   = 1'b0;
                dx_en   = 1'b0;
                xm_clr  = 1'b1;
                md_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MD_DONE: begin
                md_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset overrides everything: freeze all latches and flush them to bubbles.
        if (clr) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            dx_en   = 1'b0;
            xm_en   = 1'b0;
            fd_clr  = 1'b1;
            dx_clr  = 1'b1;
            xm_clr  = 1'b1;
            md_busy = 1'b0;
            md_done = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-phase model checked every negedge,
// plus directed vectors with literal expectations.
module tb_hazard_ctrl;

    localparam int MD = 32;

    logic       clk;
    logic       clr;
    logic [4:0] idRs, idRt, exRd;
    logic       idUsesRt, exLoad, exMdStart, exBrTaken;
    logic       pcEn, fdEn, dxEn, xmEn, fdClr, dxClr, xmClr, mdBusy, mdDone;

    int errors = 0;
    int checks = 0;
    int mdPhase = -1;
    int doneA, doneB, sawDone;

    hazard_ctrl #(.MD_CYCLES(MD)) dut (
        .clk        (clk),
        .clr        (clr),
        .id_rs      (idRs),
        .id_rt      (idRt),
        .id_uses_rt (idUsesRt),
        .ex_rd      (exRd),
        .ex_load    (exLoad),
        .ex_md_start(exMdStart),
        .ex_br_taken(exBrTaken),
        .pc_en      (pcEn),
        .fd_en      (fdEn),
        .dx_en      (dxEn),
        .xm_en      (xmEn),
        .fd_clr     (fdClr),
        .dx_clr     (dxClr),
        .xm_clr     (xmClr),
        .md_busy    (mdBusy),
        .md_done    (mdDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                 input logic [4:0] rd, input logic load, input logic start,
                                 input logic br);
        idRs      = rs;
        idRt      = rt;
        idUsesRt  = usesRt;
        exRd      = rd;
        exLoad    = load;
        exMdStart = start;
        exBrTaken = br;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Model: mdPhase counts cycles since an accepted mult/div start (-1 = not running).
    // Output vector order: pc fd dx xm fdClr dxClr xmClr busy done.
    always @(negedge clk) begin
        logic [8:0] expVec, actVec;
        logic       hazard;
        int         nextPhase;
        hazard = exLoad && exRd != 0 && (exRd == idRs || (idUsesRt && exRd == idRt));
        if (clr) begin
            expVec    = 9'b0000_111_00;
            nextPhase = -1;
        end else if (mdPhase >= 1 && mdPhase <= MD - 1) begin
            expVec    = 9'b0001_001_10;
            nextPhase = mdPhase + 1;
        end else if (mdPhase == MD) begin
            expVec    = 9'b1111_000_01;
            nextPhase = -1;
        end else if (exMdStart) begin
            expVec    = 9'b0001_001_00;
            nextPhase = 1;
        end else if (exBrTaken) begin
            expVec    = 9'b1111_110_00;
            nextPhase = -1;
        end else if (hazard) begin
            expVec    = 9'b0011_010_00;
            nextPhase = -1;
        end else begin
            expVec    = 9'b1111_000_00;
            nextPhase = -1;
        end
        actVec = {pcEn, fdEn, dxEn, xmEn, fdClr, dxClr, xmClr, mdBusy, mdDone};
        checks++;
        if (actVec !== expVec) begin
            errors++;
            $display("[TB] FAIL cycle_outputs: got %b expected %b at %0t", actVec, expVec, $time);
        end
        mdPhase = nextPhase;
    end

    initial begin
        clr = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reset held for three cycles
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_pc_en", pcEn, 1'b0);
            checkOutput("rst_xm_en", xmEn, 1'b0);
            checkOutput("rst_fd_clr", fdClr, 1'b1);
            checkOutput("rst_xm_clr", xmClr, 1'b1);
            nextCycle();
        end
        clr = 1'b0;
        @(negedge clk);
        checkOutput("rel_pc_en", pcEn, 1'b1);
        checkOutput("rel_xm_en", xmEn, 1'b1);
        checkOutput("rel_dx_clr", dxClr, 1'b0);
        checkOutput("rel_busy", mdBusy, 1'b0);
        nextCycle();

        // Load-use on rs
        applyStimulus(8, 0, 0, 8, 1, 0, 0);
        @(negedge clk);
        checkOutput("lu_pc_en", pcEn, 1'b0);
        checkOutput("lu_fd_en", fdEn, 1'b0);
        checkOutput("lu_dx_clr", dxClr, 1'b1);
        checkOutput("lu_dx_en", dxEn, 1'b1);
        nextCycle();
        // Destination r0 never stalls
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("lu_r0_pc_en", pcEn, 1'b1);
        nextCycle();
        // rt match ignored when rt is not read
        applyStimulus(3, 8, 0, 8, 1, 0, 0);
        @(negedge clk);
        checkOutput("lu_nort_pc_en", pcEn, 1'b1);
        nextCycle();
        applyStimulus(3, 8, 1, 8, 1, 0, 0);
        @(negedge clk);
        checkOutput("lu_rt_pc_en", pcEn, 1'b0);
        nextCycle();

        // Taken branch, then back to normal
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("br_fd_clr", fdClr, 1'b1);
        checkOutput("br_dx_clr", dxClr, 1'b1);
        checkOutput("br_pc_en", pcEn, 1'b1);
        checkOutput("br_xm_clr", xmClr, 1'b0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("br_after_fd_clr", fdClr, 1'b0);
        nextCycle();

        // Single mult/div with a branch injected mid-run
        for (int c = 0; c <= MD + 1; c++) begin
            applyStimulus(0, 0, 0, 0, 0, c == 0, c == 10);
            @(negedge clk);
            if (c == 0)      checkOutput("md_c0_busy", mdBusy, 1'b0);
            if (c == 0)      checkOutput("md_c0_pc_en", pcEn, 1'b0);
            if (c == 1)      checkOutput("md_c1_busy", mdBusy, 1'b1);
            if (c == 10)     checkOutput("md_c10_fd_clr", fdClr, 1'b0);
            if (c == MD - 1) checkOutput("md_c31_busy", mdBusy, 1'b1);
            if (c == MD)     checkOutput("md_c32_done", mdDone, 1'b1);
            if (c == MD + 1) checkOutput("md_c33_done", mdDone, 1'b0);
            if (c == MD + 1) checkOutput("md_c33_pc_en", pcEn, 1'b1);
            nextCycle();
        end

        // Back-to-back mult/div with start held high
        doneA = -1;
        doneB = -1;
        for (int c = 0; c <= 2 * MD + 2; c++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            if (mdDone) begin
                if (doneA < 0) doneA = c;
                else if (doneB < 0) doneB = c;
            end
            if (c == MD)     checkOutput("b2b_c32_pc_en", pcEn, 1'b1);
            if (c == MD + 1) checkOutput("b2b_c33_pc_en", pcEn, 1'b0);
            if (c == MD + 2) checkOutput("b2b_c34_busy", mdBusy, 1'b1);
            nextCycle();
        end
        checks++;
        if (doneA != MD || doneB != 2 * MD + 1) begin
            errors++;
            $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected %0d,%0d",
                     doneA, doneB, MD, 2 * MD + 1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (MD + 2) nextCycle();

        // Reset in the middle of a mult/div
        sawDone = 0;
        for (int c = 0; c < 15; c++) begin
            applyStimulus(0, 0, 0, 0, 0, c == 0, 0);
            nextCycle();
        end
        checkOutput("abort_busy_before", mdBusy, 1'b1);
        clr = 1'b1;
        #1;
        checkOutput("abort_busy_async", mdBusy, 1'b0);
        nextCycle();
        nextCycle();
        clr = 1'b0;
        for (int c = 0; c < MD + 8; c++) begin
            @(negedge clk);
            if (mdDone) sawDone++;
            nextCycle();
        end
        checks++;
        if (sawDone != 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", sawDone);
        end

        // Fresh start after the abort completes normally
        doneA = -1;
        for (int c = 0; c <= MD + 1; c++) begin
            applyStimulus(0, 0, 0, 0, 0, c == 0, 0);
            @(negedge clk);
            if (mdDone && doneA < 0) doneA = c;
            nextCycle();
        end
        checks++;
        if (doneA != MD) begin
            errors++;
            $display("[TB] FAIL restart_done_cycle: got %0d expected %0d", doneA, MD);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It drives the enable and clear inputs of every pipeline latch (PC, F/D, D/X, X/M) built from enabled, clearable flip-flops, and it is the only block that asserts them. It handles three cases: load-use stalls, taken-branch flushes in EX, and the multicycle freeze while the mult/div unit runs.

## Interface
- MD_CYCLES, 32, cycles the mult/div unit occupies EX; legal range ≥ 2
- CW, $clog2(MD_CYCLES), width of the internal countdown counter
- clk  in  1  system clock; all state changes on posedge
- clr  in  1  reset, asynchronous, active-high
- id_rs  in  5  rs field of the instruction in D
- id_rt  in  5  rt field of the instruction in D
- id_uses_rt  in  1  instruction in D reads rt
- ex_rd  in  5  destination register of the instruction in EX
- ex_load  in  1  instruction in EX is a load
- ex_md_start  in  1  instruction in EX is mult/div
- ex_br_taken  in  1  branch/jump in EX resolved taken
- pc_en, fd_en, dx_en, xm_en  out  1 each  latch enables
- fd_clr, dx_clr, xm_clr  out  1 each  synchronous-use latch clears (bubble insert)
- md_busy  out  1  mult/div in progress (registered)
- md_done  out  1  one-cycle pulse, mult/div result valid in EX this cycle

## Operation
- FSM states: IDLE, MD_RUN, MD_DONE. State and counter reset to IDLE and 0.
- **Load-use, combinational, IDLE only.** The hazard condition is: ex_load, ex_rd≠0, and ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt).
  - When it holds: pc_en=0, fd_en=0, dx_clr=1. All other enables stay 1.
- **Branch flush, IDLE only.** When ex_br_taken: fd_clr=1, dx_clr=1, pc_en=1 (PC loads the target).
  - Branch and load cannot both occupy EX, so branch and load-use are mutually exclusive by construction.
  - If both are asserted anyway, branch wins.
- **Mult/div.**
  - IDLE with ex_md_start: stall this cycle (pc_en=fd_en=dx_en=0, xm_clr=1, xm_en=1). Load counter with MD_CYCLES-2 and go to MD_RUN.
  - MD_RUN: same stall outputs. The counter decrements each cycle. When the counter is 0, go to MD_DONE.
  - MD_DONE: all enables 1, all clears 0, md_done=1. Return to IDLE unconditionally.
- ex_md_start, ex_br_taken and load-use are ignored in MD_RUN and MD_DONE.
- Priority in IDLE: ex_md_start > ex_br_taken > load-use > normal.
- Normal state (IDLE, no hazard): all enables 1, all clears 0.
- md_busy = (state==MD_RUN). md_done = (state==MD_DONE).
- **While clr is high:**
  - all enables 0, fd_clr=dx_clr=xm_clr=1, md_busy=0, md_done=0.
  - FSM forced to IDLE immediately, including mid mult/div. The aborted operation never produces md_done.

## Timing
- Load-use and branch outputs are combinational from the current inputs, with no added latency. Each hazard gives exactly one bubble or flush per cycle it is present.
- Mult/div timeline, with start seen at cycle 0:
  - cycles 0..MD_CYCLES-1: stall asserted, MD_CYCLES cycles total
  - md_busy high in cycles 1..MD_CYCLES-1
  - md_done high in cycle MD_CYCLES only
  - cycle MD_CYCLES+1: IDLE, and a new ex_md_start is accepted
- MD_CYCLES=2 gives MD_RUN for exactly 1 cycle, since the counter is loaded with 0.
- Release of clr is asynchronous in assertion only. The first IDLE evaluation happens at the first posedge after deassertion.

## Test plan
- **Reset:** hold clr 3 cycles, then release with all inputs 0.
  - During clr: all en=0, all clr outputs=1.
  - After release: pc_en=fd_en=dx_en=xm_en=1, clears 0, md_busy=0.
- **Load-use:**
  - ex_load=1, ex_rd=8, id_rs=8 for one cycle → pc_en=0, fd_en=0, dx_clr=1 that cycle.
  - Same with ex_rd=0 → no stall.
  - id_rt=8 with id_uses_rt=0 → no stall.
- **Branch:** ex_br_taken=1 for one cycle → fd_clr=1, dx_clr=1, pc_en=1, xm_clr=0. The next cycle returns to normal.
- **Mult/div, MD_CYCLES=32:** ex_md_start pulse at cycle 0.
  - Stall outputs in cycles 0–31.
  - md_busy in cycles 1–31.
  - md_done=1 only at cycle 32.
  - ex_br_taken=1 injected at cycle 10 has no effect.
- **Back-to-back mult/div:** ex_md_start held high throughout. A second 32-cycle stall begins at cycle 33, not earlier, and md_done pulses at cycles 32 and 65.
- **Reset mid-op:** assert clr at cycle 15 of a mult/div.
  - FSM goes to IDLE; md_busy drops asynchronously.
  - No md_done ever pulses.
  - After release, a normal start completes in 32 cycles.
